// File: rtl/vector_unpack.sv
// vector_unpack: captures a bit vector and streams out the indices of its set
// bits, lowest first, one index per accepted beat.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   vector handshake, payload in_data[DATA_W-1:0]
//   out_valid/out_ready index handshake
//   out_pos             index of lowest remaining set bit
//   out_count           set-bit count of the captured word
//   out_last            final beat of the word
//   out_none            captured word was all zeros (single empty beat)
module vector_unpack #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned POS_W  = $clog2(DATA_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [POS_W-1:0]    out_pos,
  output logic [POS_W:0]      out_count,
  output logic                out_last,
  output logic                out_none
);

  localparam int unsigned CNT_W = POS_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mask_q,  mask_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                emit_c;
  logic [DATA_W-1:0]   mask_clr_c;
  logic [POS_W-1:0]    low_pos_c;
  logic [CNT_W-1:0]    pop_c;
  logic                in_fire_c;
  logic                out_fire_c;

  // State, mask and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  // Lowest set bit of the mask; descending scan so the lowest index wins.
  always_comb begin
    low_pos_c = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (mask_q[i]) low_pos_c = POS_W'(i);
    end
  end

  // Population count of the incoming vector.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pop_c = pop_c + CNT_W'(in_data[i]);
    end
  end

  // Mask with its lowest set bit removed; zero here means at most one bit left.
  assign mask_clr_c = mask_q & (mask_q - DATA_W'(1));

  // Output decode and next-state logic.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    count_d   = count_q;

    emit_c    = (state_q == EMIT);
    out_valid = emit_c;
    out_pos   = emit_c ? low_pos_c : '0;
    out_count = emit_c ? count_q : '0;
    out_last  = emit_c & (mask_clr_c == '0);
    out_none  = emit_c & (mask_q == '0);

    out_fire_c = out_valid & out_ready;
    // Accepting the last beat frees the registers for a new word on the same edge.
    in_ready   = !emit_c | (out_fire_c & out_last);
    in_fire_c  = in_valid & in_ready;

    if (out_fire_c) begin
      mask_d = mask_clr_c;
      if (out_last) state_d = IDLE;
    end

    if (in_fire_c) begin
      mask_d  = in_data;
      count_d = pop_c;
      state_d = EMIT;
    end
  end

endmodule

// File: tb/tb_vector_unpack.sv
// tb_vector_unpack: directed and randomized checks of vector_unpack against a
// set-bit-list reference model.
module tb_vector_unpack;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned POS_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [POS_W-1:0]  out_pos;
  logic [POS_W:0]    out_count;
  logic              out_last;
  logic              out_none;

  int passed = 0;
  int total  = 0;

  vector_unpack #(.DATA_W(DATA_W), .POS_W(POS_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_count (out_count),
    .out_last  (out_last),
    .out_none  (out_none)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Sends one word from IDLE and drains all its beats.
  // mode 0: out_ready always 1; 1: pattern 1,0,0; 2: random.
  task automatic run_word(input logic [DATA_W-1:0] w, input int mode);
    int q[$];
    int cnt;
    int beat;
    int cyc;
    bit zero;
    for (int i = 0; i < DATA_W; i++) if (w[i]) q.push_back(i);
    cnt  = q.size();
    zero = (cnt == 0);
    if (zero) q.push_back(0);

    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = w;
    out_ready = 1'b0;
    #1 chk("in_ready_idle", int'(in_ready), 1);
    chk("idle_no_valid", int'(out_valid), 0);

    @(negedge clk);
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    cyc  = 0;
    beat = 0;
    while (q.size() > 0 && cyc < 100) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (beat % 3 == 0);
        default: out_ready = 1'($urandom);
      endcase
      #1;
      chk("out_valid", int'(out_valid), 1);
      chk("out_pos",   int'(out_pos),   q[0]);
      chk("out_count", int'(out_count), cnt);
      chk("out_last",  int'(out_last),  int'(q.size() == 1));
      chk("out_none",  int'(out_none),  int'(zero));
      chk("in_ready_emit", int'(in_ready), int'(out_ready && q.size() == 1));
      if (out_ready) void'(q.pop_front());
      beat++;
      cyc++;
      @(negedge clk);
    end
    chk("drain_left", q.size(), 0);
    out_ready = 1'($urandom);
    #1;
    chk("post_valid", int'(out_valid), 0);
    chk("post_ready", int'(in_ready), 1);
    chk("post_pos",   int'(out_pos), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset with random inputs.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_data   = DATA_W'($urandom);
      out_ready = 1'($urandom);
      #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_pos",   int'(out_pos),   0);
      chk("rst_count", int'(out_count), 0);
      chk("rst_last",  int'(out_last),  0);
      chk("rst_none",  int'(out_none),  0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1 chk("rel_in_ready", int'(in_ready), 1);

    // Directed words.
    run_word(10'h224, 0);
    run_word(10'h000, 0);
    run_word(10'h3FF, 1);

    // Back-to-back: 0x200 then 0x001 with no idle cycle.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 10'h200;
    out_ready = 1'b1;
    @(negedge clk);
    in_data = 10'h001;
    #1;
    chk("b2b_v1",    int'(out_valid), 1);
    chk("b2b_pos1",  int'(out_pos),   9);
    chk("b2b_last1", int'(out_last),  1);
    chk("b2b_cnt1",  int'(out_count), 1);
    chk("b2b_rdy1",  int'(in_ready),  1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("b2b_v2",    int'(out_valid), 1);
    chk("b2b_pos2",  int'(out_pos),   0);
    chk("b2b_last2", int'(out_last),  1);
    chk("b2b_cnt2",  int'(out_count), 1);
    @(negedge clk);
    #1 chk("b2b_idle", int'(out_valid), 0);

    // Mid-word reset.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 10'h0F0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("mr_pos4", int'(out_pos), 4);
    @(posedge clk);
    #2;
    chk("mr_pos5", int'(out_pos), 5);
    rst_n = 1'b0;
    #1;
    chk("mr_async_valid", int'(out_valid), 0);
    chk("mr_async_pos",   int'(out_pos),   0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'($urandom);
      #1 chk("mr_after_valid", int'(out_valid), 0);
    end

    // Randomized words, some forced to zero.
    for (int n = 0; n < 25; n++) begin
      logic [DATA_W-1:0] w;
      w = DATA_W'($urandom);
      if (n % 7 == 3) w = '0;
      run_word(w, 2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
